// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : VGA sync/blanking timing with 1-clock pixel request/data
//               alignment; optional colour-bar generator (VGA_TEST_PATTERN_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_SYNC  = 96,
    parameter int H_BACK  = 48,
    parameter int H_VALID = 640,
    parameter int H_FRONT = 16,
    parameter int V_SYNC  = 2,
    parameter int V_BACK  = 33,
    parameter int V_VALID = 480,
    parameter int V_FRONT = 10
) (
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    input  logic [15:0] pix_data,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        pix_req,
    output logic        hsync,
    output logic        vsync,
    output logic [15:0] rgb,
    output logic        frame_start
);

    localparam logic [9:0] c_h_total   = 10'(H_SYNC + H_BACK + H_VALID + H_FRONT);
    localparam logic [9:0] c_v_total   = 10'(V_SYNC + V_BACK + V_VALID + V_FRONT);
    localparam logic [9:0] c_h_sync    = 10'(H_SYNC);
    localparam logic [9:0] c_v_sync    = 10'(V_SYNC);
    localparam logic [9:0] c_h_act_beg = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] c_h_act_end = 10'(H_SYNC + H_BACK + H_VALID);
    localparam logic [9:0] c_v_act_beg = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] c_v_act_end = 10'(V_SYNC + V_BACK + V_VALID);
    localparam logic [9:0] c_h_req_beg = c_h_act_beg - 10'd1;
    localparam logic [9:0] c_h_req_end = c_h_act_end - 10'd1;

    logic [9:0] r_cnt_h;
    logic [9:0] r_cnt_v;
    logic       r_frame_start;

    logic w_h_last;
    logic w_v_last;
    logic w_h_act;
    logic w_h_req;
    logic w_v_act;
    logic w_rgb_valid;

    assign w_h_last = (r_cnt_h == c_h_total - 10'd1);
    assign w_v_last = (r_cnt_v == c_v_total - 10'd1);

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cnt_h       <= 10'd0;
            r_cnt_v       <= 10'd0;
            r_frame_start <= 1'b0;
        end else begin
            r_cnt_h       <= w_h_last ? 10'd0 : r_cnt_h + 10'd1;
            if (w_h_last) begin
                r_cnt_v   <= w_v_last ? 10'd0 : r_cnt_v + 10'd1;
            end
            r_frame_start <= w_h_last && w_v_last;
        end
    end

    // All outputs below decode the counters directly, so holding them at
    // (0,0) in reset yields the idle values (syncs high, no request, black).
    assign w_h_act     = (r_cnt_h >= c_h_act_beg) && (r_cnt_h < c_h_act_end);
    assign w_h_req     = (r_cnt_h >= c_h_req_beg) && (r_cnt_h < c_h_req_end);
    assign w_v_act     = (r_cnt_v >= c_v_act_beg) && (r_cnt_v < c_v_act_end);
    assign w_rgb_valid = w_h_act && w_v_act;

    assign hsync       = (r_cnt_h < c_h_sync);
    assign vsync       = (r_cnt_v < c_v_sync);
    assign pix_req     = w_h_req && w_v_act;
    assign pix_x       = pix_req ? (r_cnt_h - c_h_req_beg) : 10'h3FF;
    assign pix_y       = pix_req ? (r_cnt_v - c_v_act_beg) : 10'h3FF;
    assign frame_start = r_frame_start;

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [9:0] c_bar_w = 10'(H_VALID / 8);

    logic [9:0]  w_col;
    logic [9:0]  w_bar;
    logic [15:0] w_pattern;

    assign w_col = r_cnt_h - c_h_act_beg;
    assign w_bar = w_col / c_bar_w;

    always_comb begin
        w_pattern = 16'h0000;
        case (w_bar)
            10'd0:   w_pattern = 16'hFFFF;
            10'd1:   w_pattern = 16'hFFE0;
            10'd2:   w_pattern = 16'h07FF;
            10'd3:   w_pattern = 16'h07E0;
            10'd4:   w_pattern = 16'hF81F;
            10'd5:   w_pattern = 16'hF800;
            10'd6:   w_pattern = 16'h001F;
            default: w_pattern = 16'h0000;
        endcase
    end

    assign rgb = w_rgb_valid ? w_pattern : 16'h0000;
`else
    assign rgb = w_rgb_valid ? pix_data : 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Directed bench for vga_timing_gen on a reduced 25x11 raster.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    // Reduced raster: H = 4+3+16+2 = 25 clocks, V = 2+3+4+2 = 11 lines,
    // frame = 275 clocks. Active columns h=7..22, request columns h=6..21,
    // active rows v=5..8.
    localparam int H_TOT = 25;
    localparam int V_TOT = 11;
    localparam int FRAME = 275;

    logic        vga_clk;
    logic        sys_rst_n;
    logic [15:0] pix_data;
    logic [9:0]  w_pix_x;
    logic [9:0]  w_pix_y;
    logic        w_pix_req;
    logic        w_hsync;
    logic        w_vsync;
    logic [15:0] w_rgb;
    logic        w_frame_start;

    int n_chk = 0;
    int n_bad = 0;
    int k     = 0;

    logic [15:0] bars [8];

    vga_timing_gen #(
        .H_SYNC (4),
        .H_BACK (3),
        .H_VALID(16),
        .H_FRONT(2),
        .V_SYNC (2),
        .V_BACK (3),
        .V_VALID(4),
        .V_FRONT(2)
    ) u_dut (
        .vga_clk    (vga_clk),
        .sys_rst_n  (sys_rst_n),
        .pix_data   (pix_data),
        .pix_x      (w_pix_x),
        .pix_y      (w_pix_y),
        .pix_req    (w_pix_req),
        .hsync      (w_hsync),
        .vsync      (w_vsync),
        .rgb        (w_rgb),
        .frame_start(w_frame_start)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (k=%0d)", tag, got, exp, k);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_hsync",   32'(w_hsync),       32'd1);
        chk("rst_vsync",   32'(w_vsync),       32'd1);
        chk("rst_pix_req", 32'(w_pix_req),     32'd0);
        chk("rst_pix_x",   32'(w_pix_x),       32'h3FF);
        chk("rst_pix_y",   32'(w_pix_y),       32'h3FF);
        chk("rst_rgb",     32'(w_rgb),         32'h0);
        chk("rst_frame",   32'(w_frame_start), 32'd0);
    endtask

    // Expected outputs for the cycle k clock edges after reset release.
    task automatic check_cycle(input int kk);
        int h;
        int v;
        logic req;
        logic valid;
        logic [15:0] exp_rgb;
        h       = kk % H_TOT;
        v       = (kk / H_TOT) % V_TOT;
        req     = (h >= 6) && (h <= 21) && (v >= 5) && (v <= 8);
        valid   = (h >= 7) && (h <= 22) && (v >= 5) && (v <= 8);
`ifdef VGA_TEST_PATTERN_EN
        exp_rgb = valid ? bars[(h - 7) / 2] : 16'h0000;
`else
        exp_rgb = valid ? 16'(h - 7) : 16'h0000;
`endif
        chk("hsync",       32'(w_hsync),       32'(h < 4));
        chk("vsync",       32'(w_vsync),       32'(v < 2));
        chk("pix_req",     32'(w_pix_req),     32'(req));
        chk("pix_x",       32'(w_pix_x),       req ? 32'(h - 6) : 32'h3FF);
        chk("pix_y",       32'(w_pix_y),       req ? 32'(v - 5) : 32'h3FF);
        chk("rgb",         32'(w_rgb),         32'(exp_rgb));
        chk("frame_start", 32'(w_frame_start), 32'((kk > 0) && (kk % FRAME == 0)));
    endtask

    // Renderer stand-in: returns the previous cycle's pix_x one clock later.
    task automatic tick();
        logic [9:0] px;
        px = w_pix_x;
        @(posedge vga_clk);
        #1;
`ifdef VGA_TEST_PATTERN_EN
        pix_data = 16'h1234;
`else
        pix_data = {6'd0, px};
`endif
        #1;
        k++;
    endtask

    initial begin
        bars[0] = 16'hFFFF; bars[1] = 16'hFFE0; bars[2] = 16'h07FF; bars[3] = 16'h07E0;
        bars[4] = 16'hF81F; bars[5] = 16'hF800; bars[6] = 16'h001F; bars[7] = 16'h0000;

        sys_rst_n = 1'b0;
`ifdef VGA_TEST_PATTERN_EN
        pix_data  = 16'h1234;
`else
        pix_data  = 16'hBEEF;
`endif
        repeat (3) @(posedge vga_clk);
        #1;
        chk_reset_vals();

        @(negedge vga_clk);
        sys_rst_n = 1'b1;
        #1;
        k = 0;
        check_cycle(0);
        for (int i = 0; i < 2 * FRAME + 3; i++) begin
            tick();
            check_cycle(k);
        end

        // Advance to an active pixel mid-frame (h=12, v=6), then reset between edges.
        for (int i = 0; i < FRAME; i++) begin
            if ((k % H_TOT == 12) && ((k / H_TOT) % V_TOT == 6)) break;
            tick();
            check_cycle(k);
        end
        chk("mid_req_before_rst", 32'(w_pix_req), 32'd1);
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk_reset_vals();
        repeat (2) @(posedge vga_clk);
        #1;
        chk_reset_vals();

        @(negedge vga_clk);
        sys_rst_n = 1'b1;
        #1;
        k = 0;
        check_cycle(0);
        for (int i = 0; i < 3 * H_TOT; i++) begin
            tick();
            check_cycle(k);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
